// File: rtl/branch_station_if.sv
`default_nettype none
// ============================================================================
// branch_station_if : dispatch, result-snoop and feed buses of the branch station
// Rev 1.0
// ============================================================================
interface branch_station_if #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 6,
  parameter int NAME_W = 8
) ();
  logic              disp_valid;
  logic              disp_ready;
  logic [NAME_W-1:0] disp_name;
  logic [XLEN-1:0]   disp_address;
  logic [XLEN-1:0]   disp_immediate;
  logic [TAG_W-1:0]  disp_dst_tag;
  logic [XLEN-1:0]   disp_data_1;
  logic [TAG_W-1:0]  disp_tag_1;
  logic              disp_rdy_1;
  logic [XLEN-1:0]   disp_data_2;
  logic [TAG_W-1:0]  disp_tag_2;
  logic              disp_rdy_2;

  logic              res_valid;
  logic [TAG_W-1:0]  res_tag;
  logic [XLEN-1:0]   res_data;

  logic              feed_valid;
  logic              feed_ready;
  logic [NAME_W-1:0] feed_instr_name;
  logic [XLEN-1:0]   feed_address;
  logic [XLEN-1:0]   feed_immediate;
  logic [XLEN-1:0]   feed_data_1;
  logic [XLEN-1:0]   feed_data_2;
  logic [TAG_W-1:0]  feed_dst_tag;

  modport slave (
    input  disp_valid, disp_name, disp_address, disp_immediate, disp_dst_tag,
           disp_data_1, disp_tag_1, disp_rdy_1, disp_data_2, disp_tag_2, disp_rdy_2,
           res_valid, res_tag, res_data, feed_ready,
    output disp_ready, feed_valid, feed_instr_name, feed_address, feed_immediate,
           feed_data_1, feed_data_2, feed_dst_tag
  );

  modport master (
    output disp_valid, disp_name, disp_address, disp_immediate, disp_dst_tag,
           disp_data_1, disp_tag_1, disp_rdy_1, disp_data_2, disp_tag_2, disp_rdy_2,
           res_valid, res_tag, res_data, feed_ready,
    input  disp_ready, feed_valid, feed_instr_name, feed_address, feed_immediate,
           feed_data_1, feed_data_2, feed_dst_tag
  );
endinterface
`default_nettype wire

// File: rtl/branch_station.sv
`default_nettype none
// ============================================================================
// branch_station : out-of-order reservation station feeding the branch unit
// Rev 1.0
// ============================================================================
module branch_station #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 6,
  parameter int NAME_W = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  branch_station_if.slave bus
);
  localparam int                IDX_W     = $clog2(DEPTH);
  localparam logic [NAME_W-1:0] NAME_JAL  = NAME_W'(0);
  localparam logic [NAME_W-1:0] NAME_JALR = NAME_W'(1);

  logic [DEPTH-1:0]  valid;
  logic [DEPTH-1:0]  rdy1, rdy2;
  logic [DEPTH-1:0]  age [DEPTH];  // age[i][j] = 1: entry i is older than entry j
  logic [NAME_W-1:0] e_name [DEPTH];
  logic [XLEN-1:0]   e_addr [DEPTH];
  logic [XLEN-1:0]   e_imm  [DEPTH];
  logic [TAG_W-1:0]  e_dtag [DEPTH];
  logic [XLEN-1:0]   e_data1 [DEPTH];
  logic [XLEN-1:0]   e_data2 [DEPTH];
  logic [TAG_W-1:0]  e_tag1 [DEPTH];
  logic [TAG_W-1:0]  e_tag2 [DEPTH];

  logic              feed_valid;
  logic [NAME_W-1:0] feed_name;
  logic [XLEN-1:0]   feed_addr, feed_imm, feed_d1, feed_d2;
  logic [TAG_W-1:0]  feed_dtag;

  logic [DEPTH-1:0]  ready, has_older;
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx, free_idx;
  logic              disp_ready, dispatch, load, issue;
  logic              is_jal, is_jalr, hit1, hit2, in_rdy1, in_rdy2;
  logic [XLEN-1:0]   in_data1, in_data2;

  assign ready = valid & rdy1 & rdy2;

  always_comb begin
    has_older = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (j != i && ready[j] && age[j][i]) has_older[i] = 1'b1;
  end

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ready[i] && !has_older[i] && !sel_found) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
  end

  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid[i]) free_idx = IDX_W'(i);
  end

  assign disp_ready = ~&valid;
  assign dispatch   = bus.disp_valid && disp_ready;
  assign load       = !feed_valid || bus.feed_ready;
  assign issue      = load && sel_found;

  // JAL ignores both operands and JALR ignores operand 2, so they never wait on a tag.
  assign is_jal   = (bus.disp_name == NAME_JAL);
  assign is_jalr  = (bus.disp_name == NAME_JALR);
  assign hit1     = bus.res_valid && !bus.disp_rdy_1 && !is_jal &&
                    (bus.disp_tag_1 == bus.res_tag);
  assign hit2     = bus.res_valid && !bus.disp_rdy_2 && !is_jal && !is_jalr &&
                    (bus.disp_tag_2 == bus.res_tag);
  assign in_rdy1  = bus.disp_rdy_1 || hit1 || is_jal;
  assign in_rdy2  = bus.disp_rdy_2 || hit2 || is_jal || is_jalr;
  assign in_data1 = hit1 ? bus.res_data : bus.disp_data_1;
  assign in_data2 = hit2 ? bus.res_data : bus.disp_data_2;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.res_valid && valid[i] && !rdy1[i] && e_tag1[i] == bus.res_tag) begin
        e_data1[i] <= bus.res_data;
        rdy1[i]    <= 1'b1;
      end
      if (bus.res_valid && valid[i] && !rdy2[i] && e_tag2[i] == bus.res_tag) begin
        e_data2[i] <= bus.res_data;
        rdy2[i]    <= 1'b1;
      end
    end
    if (dispatch) begin
      e_name[free_idx]  <= bus.disp_name;
      e_addr[free_idx]  <= bus.disp_address;
      e_imm[free_idx]   <= bus.disp_immediate;
      e_dtag[free_idx]  <= bus.disp_dst_tag;
      e_data1[free_idx] <= in_data1;
      e_tag1[free_idx]  <= bus.disp_tag_1;
      rdy1[free_idx]    <= in_rdy1;
      e_data2[free_idx] <= in_data2;
      e_tag2[free_idx]  <= bus.disp_tag_2;
      rdy2[free_idx]    <= in_rdy2;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid      <= '0;
      for (int i = 0; i < DEPTH; i++) age[i] <= '0;
      feed_valid <= 1'b0;
      feed_name  <= '0;
      feed_addr  <= '0;
      feed_imm   <= '0;
      feed_d1    <= '0;
      feed_d2    <= '0;
      feed_dtag  <= '0;
    end else if (flush) begin
      valid      <= '0;
      feed_valid <= 1'b0;
    end else begin
      if (issue) valid[sel_idx] <= 1'b0;
      if (dispatch) begin
        valid[free_idx] <= 1'b1;
        // New entry is younger than everything already present.
        for (int j = 0; j < DEPTH; j++) begin
          age[free_idx][j] <= 1'b0;
          if (IDX_W'(j) != free_idx) age[j][free_idx] <= 1'b1;
        end
      end
      if (load) begin
        feed_valid <= sel_found;
        if (sel_found) begin
          feed_name <= e_name[sel_idx];
          feed_addr <= e_addr[sel_idx];
          feed_imm  <= e_imm[sel_idx];
          feed_d1   <= e_data1[sel_idx];
          feed_d2   <= e_data2[sel_idx];
          feed_dtag <= e_dtag[sel_idx];
        end
      end
    end
  end

  assign bus.disp_ready      = disp_ready;
  assign bus.feed_valid      = feed_valid;
  assign bus.feed_instr_name = feed_name;
  assign bus.feed_address    = feed_addr;
  assign bus.feed_immediate  = feed_imm;
  assign bus.feed_data_1     = feed_d1;
  assign bus.feed_data_2     = feed_d2;
  assign bus.feed_dst_tag    = feed_dtag;
endmodule
`default_nettype wire

// File: tb/tb_branch_station.sv
`default_nettype none
// ============================================================================
// tb_branch_station : scoreboard bench for branch_station
// Rev 1.0
// ============================================================================
module tb_branch_station;
  localparam int XLEN = 32, DEPTH = 4, TAG_W = 6, NAME_W = 8;
  localparam logic [7:0] JAL = 8'd0, JALR = 8'd1, BEQ = 8'd2, BNE = 8'd3;
  localparam logic [7:0] BLT = 8'd4, BGE = 8'd5, BLTU = 8'd6, BGEU = 8'd7;

  typedef struct {
    logic [7:0]  name;
    logic [31:0] addr, imm, d1, d2;
    logic [5:0]  dtag;
  } exp_t;

  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
  exp_t sb[$];
  int   vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  branch_station_if #(.XLEN(XLEN), .TAG_W(TAG_W), .NAME_W(NAME_W)) bus ();

  branch_station #(.XLEN(XLEN), .DEPTH(DEPTH), .TAG_W(TAG_W), .NAME_W(NAME_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    bus.disp_valid = 1'b0;
    bus.res_valid  = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic set_disp(input logic [7:0] name, input logic [31:0] addr, imm,
                          input logic [5:0] dtag,
                          input logic [31:0] d1, input logic [5:0] t1, input logic r1,
                          input logic [31:0] d2, input logic [5:0] t2, input logic r2);
    bus.disp_valid = 1'b1;     bus.disp_name = name;
    bus.disp_address = addr;   bus.disp_immediate = imm;  bus.disp_dst_tag = dtag;
    bus.disp_data_1 = d1;      bus.disp_tag_1 = t1;       bus.disp_rdy_1 = r1;
    bus.disp_data_2 = d2;      bus.disp_tag_2 = t2;       bus.disp_rdy_2 = r2;
  endtask

  task automatic push(input logic [7:0] name, input logic [31:0] addr, imm,
                      input logic [5:0] dtag, input logic [31:0] d1, d2);
    exp_t e;
    e.name = name; e.addr = addr; e.imm = imm; e.dtag = dtag; e.d1 = d1; e.d2 = d2;
    sb.push_back(e);
  endtask

  task automatic disp_rdy(input logic [7:0] name, input logic [31:0] addr, imm,
                          input logic [5:0] dtag, input logic [31:0] d1, d2);
    set_disp(name, addr, imm, dtag, d1, 6'd0, 1'b1, d2, 6'd0, 1'b1);
    push(name, addr, imm, dtag, d1, d2);
  endtask

  task automatic set_res(input logic [5:0] tag, input logic [31:0] data);
    bus.res_valid = 1'b1; bus.res_tag = tag; bus.res_data = data;
  endtask

  // Output register always shows the scoreboard head; it pops on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && !flush && bus.feed_valid) begin
      if (sb.size() == 0) begin
        check("spurious_feed_valid", 64'(bus.feed_valid), 64'd0);
      end else begin
        e = sb[0];
        check("feed_name", 64'(bus.feed_instr_name), 64'(e.name));
        check("feed_addr", 64'(bus.feed_address), 64'(e.addr));
        check("feed_imm",  64'(bus.feed_immediate), 64'(e.imm));
        check("feed_d1",   64'(bus.feed_data_1), 64'(e.d1));
        check("feed_d2",   64'(bus.feed_data_2), 64'(e.d2));
        check("feed_dtag", 64'(bus.feed_dst_tag), 64'(e.dtag));
        if (bus.feed_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.disp_valid = 0; bus.disp_name = 0; bus.disp_address = 0; bus.disp_immediate = 0;
    bus.disp_dst_tag = 0; bus.disp_data_1 = 0; bus.disp_tag_1 = 0; bus.disp_rdy_1 = 0;
    bus.disp_data_2 = 0; bus.disp_tag_2 = 0; bus.disp_rdy_2 = 0;
    bus.res_valid = 0; bus.res_tag = 0; bus.res_data = 0; bus.feed_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_feed_valid", 64'(bus.feed_valid), 64'd0);
    check("rst_disp_ready", 64'(bus.disp_ready), 64'd1);
    check("rst_feed_addr",  64'(bus.feed_address), 64'd0);
    reset_n = 1'b1;

    // Basic issue, dispatched in the first cycle after reset release
    disp_rdy(BEQ, 32'h100, 32'h20, 6'd1, 32'd5, 32'd5);
    check("t1_disp_ready", 64'(bus.disp_ready), 64'd1);
    step(); check("t1_lat1", 64'(bus.feed_valid), 64'd0);
    step(); check("t1_lat2", 64'(bus.feed_valid), 64'd1);
    step(); check("t1_empty", 64'(bus.feed_valid), 64'd0);

    // Wake-up from the result bus
    set_disp(BNE, 32'h200, 32'h40, 6'd2, 32'd0, 6'd7, 1'b0, 32'h11, 6'd0, 1'b1);
    step(); check("t2_wait1", 64'(bus.feed_valid), 64'd0);
    step(); check("t2_wait2", 64'(bus.feed_valid), 64'd0);
    step(); check("t2_wait3", 64'(bus.feed_valid), 64'd0);
    set_res(6'd7, 32'h55);
    push(BNE, 32'h200, 32'h40, 6'd2, 32'h55, 32'h11);
    step(); check("t2_c4", 64'(bus.feed_valid), 64'd0);
    step(); check("t2_c5", 64'(bus.feed_valid), 64'd1);
    step();

    // Dispatch bypass, then JAL/JALR don't-care operands
    set_disp(BGE, 32'h300, 32'h8, 6'd3, 32'd2, 6'd0, 1'b1, 32'd0, 6'd3, 1'b0);
    set_res(6'd3, 32'd9);
    push(BGE, 32'h300, 32'h8, 6'd3, 32'd2, 32'd9);
    step(); step(); check("t3_nostall", 64'(bus.feed_valid), 64'd1);
    set_disp(JAL, 32'h400, 32'h800, 6'd4, 32'hA, 6'd20, 1'b0, 32'hB, 6'd21, 1'b0);
    push(JAL, 32'h400, 32'h800, 6'd4, 32'hA, 32'hB);
    step();
    set_disp(JALR, 32'h500, 32'h4, 6'd5, 32'h1234, 6'd0, 1'b1, 32'hC, 6'd22, 1'b0);
    push(JALR, 32'h500, 32'h4, 6'd5, 32'h1234, 32'hC);
    step();
    repeat (4) step();
    check("t3_drain", 64'(sb.size()), 64'd0);

    // Full station with back-pressure
    bus.feed_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t4_dready_%0d", k), 64'(bus.disp_ready), 64'd1);
      disp_rdy(BLTU, 32'h1000 + 32'(k * 4), 32'(k), 6'(8 + k), 32'(k), 32'(k + 1));
      step();
    end
    check("t4_full", 64'(bus.disp_ready), 64'd0);
    set_disp(BGEU, 32'hDEAD, 32'd0, 6'd30, 32'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1);
    step();
    check("t4_full_hold", 64'(bus.disp_ready), 64'd0);
    check("t4_fv_hold", 64'(bus.feed_valid), 64'd1);
    repeat (3) step();
    bus.feed_ready = 1'b1;
    repeat (8) step();
    check("t4_drain", 64'(sb.size()), 64'd0);
    check("t4_dready_after", 64'(bus.disp_ready), 64'd1);

    // Oldest-first selection
    set_disp(BLT, 32'h2000, 32'h0, 6'd12, 32'd0, 6'd10, 1'b0, 32'd3, 6'd0, 1'b1);
    step();
    disp_rdy(BEQ, 32'h2100, 32'h4, 6'd13, 32'd1, 32'd1);
    step();
    repeat (3) step();
    check("t5_b_first", 64'(sb.size()), 64'd0);
    set_res(6'd10, 32'hAA);
    push(BLT, 32'h2000, 32'h0, 6'd12, 32'hAA, 32'd3);
    disp_rdy(BNE, 32'h2200, 32'h8, 6'd14, 32'd7, 32'd7);
    step();
    repeat (4) step();
    check("t5_drain", 64'(sb.size()), 64'd0);

    // Flush with the output register and three entries occupied
    bus.feed_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp_rdy(BGE, 32'h3000 + 32'(k * 4), 32'd0, 6'(16 + k), 32'(k), 32'(k));
      step();
    end
    check("t6_fv_before", 64'(bus.feed_valid), 64'd1);
    flush = 1'b1;
    sb.delete();
    step();
    check("t6_fv_after", 64'(bus.feed_valid), 64'd0);
    check("t6_dready", 64'(bus.disp_ready), 64'd1);
    bus.feed_ready = 1'b1;
    repeat (4) step();

    // Asynchronous reset mid-issue
    bus.feed_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp_rdy(BLTU, 32'h4000 + 32'(k * 4), 32'd1, 6'(24 + k), 32'(k + 9), 32'(k));
      step();
    end
    check("t7_fv_before", 64'(bus.feed_valid), 64'd1);
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    check("t7_fv_reset", 64'(bus.feed_valid), 64'd0);
    check("t7_d1_reset", 64'(bus.feed_data_1), 64'd0);
    check("t7_dready", 64'(bus.disp_ready), 64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus.feed_ready = 1'b1;
    disp_rdy(BEQ, 32'h5000, 32'h10, 6'd31, 32'd42, 32'd42);
    step(); step();
    check("t7_first_edge", 64'(bus.feed_valid), 64'd1);
    step();

    for (int w = 0; w < 50 && sb.size() != 0; w++) step();
    check("final_drain", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
